// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg
//   Shared definitions for the instruction fetch unit: fetch FSM state
//   encoding, default reset PC, the NOP word substituted on faults, the
//   instruction/PC widths, and a small alignment helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package ifu_pkg;

    localparam int          IFU_PC_W     = 32;
    localparam int          IFU_INST_W   = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    // addi x0, x0, 0 -- what decode sees in place of a faulting fetch
    localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;

    // S_REQ  : request phase, address driven from pc
    // S_WAIT : one request outstanding, waiting for its response
    // S_HOLD : fetched instruction presented to decode
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } ifu_state_e;

    // Instructions are 32-bit, so any PC with low bits set is misaligned.
    function automatic logic pc_aligned(input logic [1:0] pc_low);
        return pc_low == 2'b00;
    endfunction

endpackage

// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu
//   Instruction fetch unit for the multi-cycle core. Owns the PC, issues one
//   32-bit fetch at a time over a request/response memory port and presents
//   {inst, pc, fault} to decode over valid/ready. Redirects (branch, jump,
//   trap) arrive from execute as a one-cycle strobe.
//
// Ports:
//   clk_i             in   clock
//   rst_n_i           in   asynchronous active-low reset
//   redirect_valid_i  in   execute redirect strobe (one cycle)
//   redirect_pc_i     in   redirect target
//   imem_req_valid_o  out  fetch request valid
//   imem_req_ready_i  in   memory accepts the request
//   imem_req_addr_o   out  fetch address
//   imem_rsp_valid_i  in   response valid (memory is never back-pressured)
//   imem_rsp_data_i   in   instruction word
//   imem_rsp_err_i    in   access fault on this response
//   if_valid_o        out  instruction valid to decode
//   if_ready_i        in   decode accepts
//   if_inst_o         out  instruction word (NOP_INST on a fault)
//   if_pc_o           out  PC of if_inst_o
//   if_fault_o        out  bus error or misaligned PC
// ---------------------------------------------------------------------------
module ifu
    import ifu_pkg::*;
#(
    parameter int                PC_W     = IFU_PC_W,
    parameter logic [PC_W-1:0]   RESET_PC = PC_W'(IFU_RESET_PC),
    parameter logic [31:0]       NOP_INST = IFU_NOP_INST
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  redirect_valid_i,
    input  logic [PC_W-1:0]       redirect_pc_i,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [PC_W-1:0]       imem_req_addr_o,
    input  logic                  imem_rsp_valid_i,
    input  logic [IFU_INST_W-1:0] imem_rsp_data_i,
    input  logic                  imem_rsp_err_i,
    output logic                  if_valid_o,
    input  logic                  if_ready_i,
    output logic [IFU_INST_W-1:0] if_inst_o,
    output logic [PC_W-1:0]       if_pc_o,
    output logic                  if_fault_o
);

    ifu_state_e      state;
    logic [PC_W-1:0] pc;
    // Set when a redirect lands while a fetch is in flight: the response
    // still has to be consumed, but its data belongs to the old path.
    logic            kill;

    logic [PC_W-1:0] pc_next_seq;
    assign pc_next_seq = pc + PC_W'(4);

    // The request side decodes straight from state and pc so the address is
    // visible in the same cycle the FSM enters S_REQ. A misaligned pc never
    // reaches memory; it is turned into a fault locally. The request is also
    // held off while reset is asserted, because the reset state is S_REQ.
    always_comb begin
        imem_req_valid_o = rst_n_i && (state == S_REQ) && pc_aligned(pc[1:0]);
        imem_req_addr_o  = pc;
    end

    // Fetch FSM plus the decode-facing output register. The if_* outputs
    // only change on entry to S_HOLD (load) or on leaving it (valid drop),
    // which keeps them stable while decode stalls.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            if_valid_o <= 1'b0;
            if_inst_o  <= '0;
            if_pc_o    <= '0;
            if_fault_o <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (!pc_aligned(pc[1:0])) begin
                        // A redirect arriving now supersedes the bad pc, so
                        // the fault is only raised if nobody steers away.
                        if (redirect_valid_i) begin
                            pc <= redirect_pc_i;
                        end else begin
                            if_inst_o  <= NOP_INST;
                            if_pc_o    <= pc;
                            if_fault_o <= 1'b1;
                            if_valid_o <= 1'b1;
                            pc         <= pc_next_seq;
                            state      <= S_HOLD;
                        end
                    end else if (imem_req_ready_i) begin
                        state <= S_WAIT;
                        if (redirect_valid_i) begin
                            kill <= 1'b1;
                            pc   <= redirect_pc_i;
                        end
                    end else if (redirect_valid_i) begin
                        pc <= redirect_pc_i;
                    end
                end

                S_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        if (kill || redirect_valid_i) begin
                            // Stale response: drop it. pc already holds the
                            // redirect target when kill was set earlier.
                            kill  <= 1'b0;
                            state <= S_REQ;
                            if (redirect_valid_i) begin
                                pc <= redirect_pc_i;
                            end
                        end else begin
                            if_inst_o  <= imem_rsp_err_i ? NOP_INST : imem_rsp_data_i;
                            if_fault_o <= imem_rsp_err_i;
                            if_pc_o    <= pc;
                            if_valid_o <= 1'b1;
                            pc         <= pc_next_seq;
                            state      <= S_HOLD;
                        end
                    end else if (redirect_valid_i) begin
                        kill <= 1'b1;
                        pc   <= redirect_pc_i;
                    end
                end

                S_HOLD: begin
                    // Decode flushes on the redirect strobe itself, so a
                    // same-cycle if_ready_i handshake does not count.
                    if (redirect_valid_i) begin
                        if_valid_o <= 1'b0;
                        pc         <= redirect_pc_i;
                        state      <= S_REQ;
                    end else if (if_ready_i) begin
                        if_valid_o <= 1'b0;
                        state      <= S_REQ;
                    end
                end

                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// ---------------------------------------------------------------------------
// tb_ifu
//   Directed scoreboard bench for ifu. A behavioural instruction memory
//   answers accepted requests after a configurable latency and checks every
//   accepted address against an expected-address queue. The stimulus script
//   pushes hand-computed decode items into a queue; a monitor pops one each
//   time if_valid_o rises and checks the outputs stay stable while held.
// ---------------------------------------------------------------------------
module tb_ifu;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } item_t;

    logic        clk_i;
    logic        rst_n_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        imem_rsp_err_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
    logic        if_fault_o;

    int          n_vec = 0;
    int          n_err = 0;
    item_t       exp_q[$];
    logic [31:0] exp_addr_q[$];
    int          rsp_delay = 1;
    logic [31:0] err_addr  = 32'hFFFF_FFFF;

    ifu #(
        .PC_W     (32),
        .RESET_PC (32'h8000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .if_valid_o       (if_valid_o),
        .if_ready_i       (if_ready_i),
        .if_inst_o        (if_inst_o),
        .if_pc_o          (if_pc_o),
        .if_fault_o       (if_fault_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Memory contents: the first word is the addi from the bring-up program,
    // everything else encodes its own address in the upper half.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0050_0093;
        return {a[15:0], 16'h0113};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc,
                                 input logic rdy);
        redirect_valid_i = rv;
        redirect_pc_i    = rpc;
        if_ready_i       = rdy;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!if_valid_o && cycles < 50) begin
            step();
            cycles++;
        end
        if (!if_valid_o) checkOutput("valid_timeout", 32'(if_valid_o), 32'd1);
    endtask

    // Returns just after the edge on which a request handshake completes.
    task automatic wait_hs();
        int   n;
        logic seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 50) begin
            @(negedge clk_i);
            seen = imem_req_valid_o && imem_req_ready_i;
            n++;
        end
        if (!seen) checkOutput("req_timeout", 32'(seen), 32'd1);
        step();
    endtask

    task automatic pulse_ready();
        applyStimulus(1'b0, 32'h0, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
    endtask

    // Instruction memory: a handshake seen at a negedge completes on the next
    // posedge; the response is driven rsp_delay cycles later for one cycle.
    initial begin : memory
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        pend = 1'b0;
        cnt  = 0;
        paddr = '0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        imem_rsp_err_i   = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                pend = 1'b0;
            end else if (imem_req_valid_o && imem_req_ready_i) begin
                if (pend) checkOutput("second_outstanding", 32'(pend), 32'd0);
                if (exp_addr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL unexpected_req: got addr %h, required none",
                             imem_req_addr_o);
                end else begin
                    checkOutput("req_addr", imem_req_addr_o, exp_addr_q.pop_front());
                end
                pend  = 1'b1;
                cnt   = rsp_delay;
                paddr = imem_req_addr_o;
            end
            @(posedge clk_i);
            #1;
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = '0;
            imem_rsp_err_i   = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid_i = 1'b1;
                    imem_rsp_data_i  = mem_word(paddr);
                    imem_rsp_err_i   = (paddr == err_addr);
                    pend = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: a rising if_valid_o is a new item; while it stays
    // high the outputs must match the item that was popped.
    initial begin : monitor
        item_t held;
        logic  held_ok;
        logic  prev_valid;
        held       = '0;
        held_ok    = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                prev_valid = 1'b0;
            end else begin
                if (if_valid_o && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        held_ok = 1'b0;
                        n_vec++;
                        n_err++;
                        $display("[TB] FAIL unexpected_item: got pc %h, required none",
                                 if_pc_o);
                    end else begin
                        held    = exp_q.pop_front();
                        held_ok = 1'b1;
                        checkOutput("item_inst",  if_inst_o,         held.inst);
                        checkOutput("item_pc",    if_pc_o,           held.pc);
                        checkOutput("item_fault", 32'(if_fault_o),   32'(held.fault));
                    end
                end else if (if_valid_o && held_ok) begin
                    checkOutput("hold_inst",  if_inst_o,       held.inst);
                    checkOutput("hold_pc",    if_pc_o,         held.pc);
                    checkOutput("hold_fault", 32'(if_fault_o), 32'(held.fault));
                end
                prev_valid = if_valid_o;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no finish, required finish");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin : stimulus
        int cyc;
        rst_n_i          = 1'b0;
        imem_req_ready_i = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        step();
        step();

        // Reset values
        checkOutput("rst_if_valid", 32'(if_valid_o),       32'd0);
        checkOutput("rst_if_inst",  if_inst_o,             32'd0);
        checkOutput("rst_if_pc",    if_pc_o,               32'd0);
        checkOutput("rst_if_fault", 32'(if_fault_o),       32'd0);
        checkOutput("rst_req_vld",  32'(imem_req_valid_o), 32'd0);

        // First fetch from the reset PC, valid two edges after release
        exp_addr_q.push_back(32'h8000_0000);
        exp_q.push_back('{32'h0050_0093, 32'h8000_0000, 1'b0});
        rst_n_i = 1'b1;
        wait_valid(cyc);
        checkOutput("first_latency", 32'(cyc), 32'd2);

        // Sequential fetch, then decode stalls 5 cycles with no new request
        exp_addr_q.push_back(32'h8000_0004);
        exp_q.push_back('{32'h0004_0113, 32'h8000_0004, 1'b0});
        pulse_ready();
        wait_valid(cyc);
        for (int i = 0; i < 5; i++) begin
            checkOutput("no_req_in_hold", 32'(imem_req_valid_o), 32'd0);
            step();
        end

        // Bus error on 0x80000008
        err_addr = 32'h8000_0008;
        exp_addr_q.push_back(32'h8000_0008);
        exp_q.push_back('{32'h0000_0013, 32'h8000_0008, 1'b1});
        pulse_ready();
        wait_valid(cyc);

        // Redirect while waiting on a slow response: response is discarded
        rsp_delay = 3;
        exp_addr_q.push_back(32'h8000_000C);
        pulse_ready();
        wait_hs();
        exp_addr_q.push_back(32'h8000_0100);
        exp_q.push_back('{32'h0100_0113, 32'h8000_0100, 1'b0});
        rsp_delay = 1;
        applyStimulus(1'b1, 32'h8000_0100, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("killed_no_valid", 32'(if_valid_o), 32'd0);
            step();
        end
        wait_valid(cyc);

        // Redirect and ready in the same hold cycle: redirect wins
        exp_addr_q.push_back(32'h8000_0104);
        exp_q.push_back('{32'h0104_0113, 32'h8000_0104, 1'b0});
        pulse_ready();
        wait_valid(cyc);
        exp_addr_q.push_back(32'h8000_0200);
        exp_q.push_back('{32'h0200_0113, 32'h8000_0200, 1'b0});
        applyStimulus(1'b1, 32'h8000_0200, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("redir_drops_valid", 32'(if_valid_o), 32'd0);
        wait_valid(cyc);

        // Redirect to a misaligned PC while a request is stalled
        imem_req_ready_i = 1'b0;
        pulse_ready();
        exp_q.push_back('{32'h0000_0013, 32'h8000_0102, 1'b1});
        exp_q.push_back('{32'h0000_0013, 32'h8000_0106, 1'b1});
        applyStimulus(1'b1, 32'h8000_0102, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("misaligned_no_req", 32'(imem_req_valid_o), 32'd0);
        wait_valid(cyc);
        pulse_ready();
        wait_valid(cyc);

        // Redirect out of the fault, then reset in the middle of S_WAIT
        imem_req_ready_i = 1'b1;
        rsp_delay = 3;
        exp_addr_q.push_back(32'h8000_0300);
        applyStimulus(1'b1, 32'h8000_0300, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0);
        wait_hs();
        #2;
        rst_n_i = 1'b0;
        #1;
        checkOutput("async_if_valid", 32'(if_valid_o),       32'd0);
        checkOutput("async_if_inst",  if_inst_o,             32'd0);
        checkOutput("async_if_pc",    if_pc_o,               32'd0);
        checkOutput("async_if_fault", 32'(if_fault_o),       32'd0);
        checkOutput("async_req_vld",  32'(imem_req_valid_o), 32'd0);
        step();
        step();

        checkOutput("items_left", 32'(exp_q.size()),      32'd0);
        checkOutput("addrs_left", 32'(exp_addr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
